// File: rtl/inst_buffer_pkg.sv
// Shared widths and entry layout for the instruction buffer between
// branch pre-decode and the decoder.
package inst_buffer_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_DATE_W = 32;
  localparam int FETCH_W     = 8;
  localparam int ISSUE_W     = 2;

  // Entry layout: {mode, pc, redir, date}
  localparam int DATE_LSB  = 0;
  localparam int REDIR_LSB = DATE_LSB + INST_DATE_W;
  localparam int PC_LSB    = REDIR_LSB + INST_ADDR_W;
  localparam int MODE_BIT  = PC_LSB + INST_ADDR_W;
  localparam int ENTRY_W   = MODE_BIT + 1;

  function automatic logic [ENTRY_W-1:0] packEntry(
    input logic                   mode,
    input logic [INST_ADDR_W-1:0] pc,
    input logic [INST_ADDR_W-1:0] redir,
    input logic [INST_DATE_W-1:0] date
  );
    return {mode, pc, redir, date};
  endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Pre-decode / decoder / control side signals of the instruction buffer.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
);
  logic                           IbFlash;
  logic [FETCH_W-1:0]             InAble;
  logic [FETCH_W-1:0]             InMode;
  logic [FETCH_W*INST_ADDR_W-1:0] InPc;
  logic [FETCH_W*INST_ADDR_W-1:0] InRedir;
  logic [FETCH_W*INST_DATE_W-1:0] InDate;
  logic                           IbReady;
  logic                           DecodeStop;
  logic                           OutInst1Able;
  logic                           OutInst1Mode;
  logic [INST_ADDR_W-1:0]         OutInst1Pc;
  logic [INST_ADDR_W-1:0]         OutInst1Redir;
  logic [INST_DATE_W-1:0]         OutInst1Date;
  logic                           OutInst2Able;
  logic                           OutInst2Mode;
  logic [INST_ADDR_W-1:0]         OutInst2Pc;
  logic [INST_ADDR_W-1:0]         OutInst2Redir;
  logic [INST_DATE_W-1:0]         OutInst2Date;
  logic [PTR_W:0]                 IbCount;

  modport master (
    output IbFlash, InAble, InMode, InPc, InRedir, InDate, DecodeStop,
    input  IbReady, IbCount,
    input  OutInst1Able, OutInst1Mode, OutInst1Pc, OutInst1Redir, OutInst1Date,
    input  OutInst2Able, OutInst2Mode, OutInst2Pc, OutInst2Redir, OutInst2Date
  );

  modport slave (
    input  IbFlash, InAble, InMode, InPc, InRedir, InDate, DecodeStop,
    output IbReady, IbCount,
    output OutInst1Able, OutInst1Mode, OutInst1Pc, OutInst1Redir, OutInst1Date,
    output OutInst2Able, OutInst2Mode, OutInst2Pc, OutInst2Redir, OutInst2Date
  );
endinterface

// File: rtl/inst_buffer_prefix_count.sv
// Leading-ones count of the fetch-group valid mask, with a flag for
// masks that are not a contiguous prefix from lane 0.
module ib_prefix_count
  import inst_buffer_pkg::*;
(
  input  logic [FETCH_W-1:0] InAble,
  output logic [3:0]         LeadOnes,
  output logic               NonPrefix
);
  logic run;

  always_comb begin
    LeadOnes  = '0;
    NonPrefix = 1'b0;
    run       = 1'b1;
    for (int k = 0; k < FETCH_W; k++) begin
      if (run && InAble[k]) begin
        LeadOnes = LeadOnes + 4'd1;
      end else begin
        run = 1'b0;
        if (InAble[k]) NonPrefix = 1'b1;
      end
    end
  end
endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer: up to 8 pushes and 2 in-order pops per cycle,
// flushable, with conservative full-group back-pressure.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
)(
  input logic        Clk,
  input logic        Rest,
  inst_buffer_if.slave ib
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count, freeSlots, pushAmt;
  logic [3:0]         pushNum;
  logic               nonPrefix, pushEn;
  logic [1:0]         popNum;
  logic [ENTRY_W-1:0] entry1, entry2;

  ib_prefix_count uPrefix (
    .InAble   (ib.InAble),
    .LeadOnes (pushNum),
    .NonPrefix(nonPrefix)
  );

  // Readiness ignores this cycle's pop so pre-decode never sees a late decision.
  assign freeSlots  = (PTR_W+1)'(DEPTH) - count;
  assign ib.IbReady = freeSlots >= (PTR_W+1)'(FETCH_W);
  assign pushEn     = ib.IbReady && (pushNum != 4'd0) && !ib.IbFlash;
  assign pushAmt    = pushEn ? (PTR_W+1)'(pushNum) : '0;

  always_comb begin
    popNum = 2'd0;
    if (!ib.DecodeStop) begin
      if (count >= (PTR_W+1)'(ISSUE_W)) popNum = 2'd2;
      else                              popNum = count[1:0];
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (ib.IbFlash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(popNum);
      tail  <= tail + PTR_W'(pushAmt);
      count <= count + pushAmt - (PTR_W+1)'(popNum);
    end
  end

  always_ff @(posedge Clk) begin
    if (pushEn) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (k < int'(pushNum)) begin
          mem[tail + PTR_W'(k)] <= packEntry(ib.InMode[k],
                                             ib.InPc[INST_ADDR_W*k +: INST_ADDR_W],
                                             ib.InRedir[INST_ADDR_W*k +: INST_ADDR_W],
                                             ib.InDate[INST_DATE_W*k +: INST_DATE_W]);
        end
      end
    end
  end

  assign ib.OutInst1Able = count != '0;
  assign ib.OutInst2Able = count >= (PTR_W+1)'(2);
  assign entry1 = ib.OutInst1Able ? mem[head]              : '0;
  assign entry2 = ib.OutInst2Able ? mem[head + PTR_W'(1)]  : '0;

  assign ib.OutInst1Mode  = entry1[MODE_BIT];
  assign ib.OutInst1Pc    = entry1[PC_LSB    +: INST_ADDR_W];
  assign ib.OutInst1Redir = entry1[REDIR_LSB +: INST_ADDR_W];
  assign ib.OutInst1Date  = entry1[DATE_LSB  +: INST_DATE_W];
  assign ib.OutInst2Mode  = entry2[MODE_BIT];
  assign ib.OutInst2Pc    = entry2[PC_LSB    +: INST_ADDR_W];
  assign ib.OutInst2Redir = entry2[REDIR_LSB +: INST_ADDR_W];
  assign ib.OutInst2Date  = entry2[DATE_LSB  +: INST_DATE_W];
  assign ib.IbCount       = count;

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      assert (!nonPrefix) else $error("inst_buffer: InAble %b is not a contiguous prefix", ib.InAble);
      assert (count <= (PTR_W+1)'(DEPTH)) else $error("inst_buffer: occupancy %0d exceeds depth", count);
    end
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction buffer between the branch pre-decode stage and the decoder.
- Accepts up to 8 pre-decoded instructions per cycle (valid, mode, PC, redirect target, instruction word) from pre-decode.
- Issues up to 2 instructions per cycle, in program order, to the decoder.
- Provides back-pressure to pre-decode and is cleared by a pipeline flush from the control block.

Parameters:
- DEPTH, 32, number of entries; power of 2, minimum 16.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rest  in  1  reset; asynchronous, active-high.
- IbFlash  in  1  flush from the control block; empties the buffer.
- InAble  in  8  per-lane valid; bit k = k-th instruction of the fetch group; must be a contiguous prefix from bit 0.
- InMode  in  8  per-lane predicted-taken flag.
- InPc  in  256  lane k PC, bits [32k+31:32k].
- InRedir  in  256  lane k predicted redirect target.
- InDate  in  256  lane k instruction word.
- IbReady  out  1  buffer can take a full 8-lane group this cycle; drives pre-decode stop.
- DecodeStop  in  1  decoder stall; when 1, nothing is popped.
- OutInst1Able  out  1  oldest entry valid.
- OutInst1Mode  out  1  oldest entry mode.
- OutInst1Pc  out  32  oldest entry PC.
- OutInst1Redir  out  32  oldest entry redirect target.
- OutInst1Date  out  32  oldest entry instruction word.
- OutInst2Able / Mode / Pc / Redir / Date  out  1/1/32/32/32  second-oldest entry, same fields.
- IbCount  out  PTR_W+1  occupancy.

Behaviour:
- Storage:
  - Circular array of DEPTH entries, 97 bits each (mode, pc, redir, date).
  - head = oldest entry, tail = next write slot, count = occupancy (PTR_W+1 bits).
  - Array contents are not reset.
- Reset (Rest=1, asynchronous):
  - head=0, tail=0, count=0.
  - All Out* outputs 0, IbReady=1, IbCount=0.
- IbReady (combinational):
  - IbReady = (DEPTH - count) >= 8.
  - Uses count before this cycle's pop; conservative by design.
- Push:
  - push_n = number of leading ones in InAble (0..8).
  - Write occurs when IbReady & push_n != 0 & !IbFlash.
  - Lane k is written to entry (tail+k) mod DEPTH for k < push_n.
  - tail advances by push_n, with wrap-around.
- Illegal InAble:
  - A non-prefix pattern (e.g. 8'b0000_0101) is illegal.
  - Only the prefix is written (here 1 lane).
  - A simulation assertion fires.
- Push while not ready: pushes while IbReady=0 are ignored; pre-decode must hold its data.
- Output (combinational from head):
  - OutInst1Able = count >= 1; OutInst2Able = count >= 2.
  - Data fields read entries head and head+1 (mod DEPTH).
  - Data fields are forced to 0 when the matching Able is 0.
- Pop:
  - pop_n = DecodeStop ? 0 : (count >= 2 ? 2 : count).
  - head advances by pop_n, with wrap-around.
  - Latency: an instruction written at edge N is visible on Out at cycle N+1 when the buffer was empty.
- Simultaneous push and pop: count' = count + push_n - pop_n. Overflow and underflow are impossible by construction; assertions check count <= DEPTH.
- Flush:
  - IbFlash=1 sets head=0, tail=0, count=0 at the next edge.
  - It overrides any push and pop in the same cycle.
  - OutInst*Able drops to 0 in the following cycle.
- Pointer arithmetic: modulo DEPTH by natural PTR_W-bit truncation.

Decomposition:
- Shared package / define file:
  - InstAddrBus and InstDateBus widths (32).
  - Fetch width (8) and issue width (2).
  - IB entry field layout offsets.
- One sub-module, ib_prefix_count: 8-bit InAble to a 4-bit leading-ones count plus a non-prefix error flag.
- No further hierarchy.

Test Plan:
- Reset, then push InAble=8'hFF with Pc=0x1C000000+4k and DecodeStop=1 → IbCount=8; Out1Pc=0x1C000000, Out2Pc=0x1C000004; both Able=1.
- Continuing from that state, push 3 more groups of 8 → IbCount=32, IbReady=0; a 5th push with InAble=8'hFF leaves IbCount=32 and contents unchanged.
- From full, release DecodeStop for 12 cycles → 24 pops; Out1Pc sequence is strictly +4 per instruction; IbReady=1 from the cycle count first reaches 24 (free=8); tail wrap is covered by refilling.
- Count=1 with DecodeStop=0, push InAble=8'h07 → pop 1 and push 3 in the same cycle; IbCount=3; Out1Pc = first pushed lane PC.
- Count=10 with IbFlash=1 and InAble=8'hFF in the same cycle → next cycle IbCount=0, both Able=0, and the new group is discarded.
- Assert Rest mid-stream (count=17) between edges → outputs go to 0 immediately; IbCount=0, IbReady=1 without waiting for a clock edge.
